// File: rtl/housekeeping_spi_master.sv
// housekeeping_spi_master: byte-level SPI mode-0 initiator driving the housekeeping SPI slave
module housekeeping_spi_master #(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] addr,
    input  logic [2:0] nbytes,
    input  logic [7:0] wdata,
    output logic       wdata_ack,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       csb,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam logic [7:0] DIV    = 8'(CLKDIV);
    localparam logic [7:0] DIV_M1 = 8'(CLKDIV - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, tx_sr, tx_sr_n, addr_q, addr_q_n, rdata_n, next_byte;
    logic [6:0] rx_sr, rx_sr_n;
    logic [3:0] byte_cnt, byte_cnt_n;
    logic [2:0] bit_cnt, bit_cnt_n, nb_q, nb_q_n;
    logic       wr_q, wr_q_n, rd_q, rd_q_n;
    logic       sck_n, csb_n, mosi_n, busy_n, done_n, ack_n, rv_n;
    logic       tick, rise, fall, last_byte;

    assign tick      = cnt == 8'd0;
    assign rise      = tick && (state == SETUP || (state == SHIFT && !sck));
    assign fall      = tick && state == SHIFT && sck;
    assign last_byte = byte_cnt == (nb_q == 3'd0 ? 4'd9 : {1'b0, nb_q} + 4'd1);
    assign next_byte = byte_cnt == 4'd0 ? addr_q : (wr_q ? wdata : 8'h00);

    // Next-state and next-output logic: phase divider, bit/byte sequencing, shift registers
    always_comb begin
        state_n    = state;
        cnt_n      = tick ? DIV_M1 : cnt - 8'd1;
        tx_sr_n    = tx_sr;
        rx_sr_n    = rx_sr;
        rdata_n    = rdata;
        byte_cnt_n = byte_cnt;
        bit_cnt_n  = bit_cnt;
        wr_q_n     = wr_q;
        rd_q_n     = rd_q;
        addr_q_n   = addr_q;
        nb_q_n     = nb_q;
        sck_n      = sck;
        csb_n      = csb;
        mosi_n     = mosi;
        busy_n     = busy;
        done_n     = 1'b0;
        ack_n      = 1'b0;
        rv_n       = 1'b0;
        case (state)
            IDLE: if (start && (wr || rd)) begin
                state_n    = SETUP;
                cnt_n      = DIV;
                wr_q_n     = wr;
                rd_q_n     = rd;
                addr_q_n   = addr;
                nb_q_n     = nbytes;
                tx_sr_n    = {wr, rd, nbytes, 3'b000};
                byte_cnt_n = 4'd0;
                bit_cnt_n  = 3'd0;
            end
            SETUP: begin
                csb_n  = 1'b0;
                busy_n = 1'b1;
                mosi_n = tx_sr[7];
                if (tick) state_n = SHIFT;
            end
            SHIFT: ;
            HOLD: if (tick) begin
                csb_n   = 1'b1;
                done_n  = 1'b1;
                state_n = GAP;
            end
            GAP: if (tick) begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rise) begin
            sck_n   = 1'b1;
            rx_sr_n = {rx_sr[5:0], miso};
            if (bit_cnt == 3'd7 && byte_cnt >= 4'd2 && rd_q) begin
                rdata_n = {rx_sr, miso};
                rv_n    = 1'b1;
            end
        end
        if (fall) begin
            sck_n     = 1'b0;
            bit_cnt_n = bit_cnt + 3'd1;
            tx_sr_n   = {tx_sr[6:0], 1'b0};
            mosi_n    = tx_sr[6];
            if (bit_cnt == 3'd7) begin
                byte_cnt_n = byte_cnt + 4'd1;
                tx_sr_n    = next_byte;
                mosi_n     = last_byte ? 1'b0 : next_byte[7];
                ack_n      = wr_q && byte_cnt != 4'd0 && !last_byte;
                if (last_byte) state_n = HOLD;
            end
        end
    end

    // State and output registers; reset forces the bus idle immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            tx_sr       <= 8'd0;
            rx_sr       <= 7'd0;
            addr_q      <= 8'd0;
            byte_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            nb_q        <= 3'd0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rdata       <= 8'h00;
            sck         <= 1'b0;
            csb         <= 1'b1;
            mosi        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wdata_ack   <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tx_sr       <= tx_sr_n;
            rx_sr       <= rx_sr_n;
            addr_q      <= addr_q_n;
            byte_cnt    <= byte_cnt_n;
            bit_cnt     <= bit_cnt_n;
            nb_q        <= nb_q_n;
            wr_q        <= wr_q_n;
            rd_q        <= rd_q_n;
            rdata       <= rdata_n;
            sck         <= sck_n;
            csb         <= csb_n;
            mosi        <= mosi_n;
            busy        <= busy_n;
            done        <= done_n;
            wdata_ack   <= ack_n;
            rdata_valid <= rv_n;
        end
    end
endmodule

// File: tb/tb_housekeeping_spi_master.sv
// tb_housekeeping_spi_master: scoreboard bench for the SPI initiator at CLKDIV 2, 1 and 255
module tb_housekeeping_spi_master;
    logic       clk = 1'b0, resetn = 1'b0, start = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [2:0] nbytes = 3'd0;
    logic [7:0] wdata;
    logic       miso;
    logic [2:0] sck_v, csb_v, mosi_v, busy_v, done_v, ack_v, rv_v;
    logic [7:0] rdata_v [3];
    logic       sck, csb, mosi, busy, done, ack, rv;
    logic [7:0] rdata;
    int         sel = 0, div, cyc = 0, t0 = 0, nchk = 0, nerr = 0;
    int         last_t = 0, nbit = 0, sidx = 99, wd_idx = 0;
    int         pulses = 0, acks = 0, rvs = 0, dones = 0, frames = 0, done_at = 0, bfall_at = 0;
    logic       p_sck = 1'b0, p_csb = 1'b1, p_busy = 1'b0;
    logic [7:0] mb = 8'h00;
    logic [7:0] wd_arr [8];
    logic [63:0] slv_data = 64'h0;
    logic [7:0] exp_mosi [$];
    logic [7:0] exp_rd [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        housekeeping_spi_master #(.CLKDIV(g == 0 ? 2 : (g == 1 ? 1 : 255))) dut (
            .clk(clk), .resetn(resetn), .start(start && sel == g), .wr(wr), .rd(rd),
            .addr(addr), .nbytes(nbytes), .wdata(wdata), .wdata_ack(ack_v[g]),
            .rdata(rdata_v[g]), .rdata_valid(rv_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .sck(sck_v[g]), .csb(csb_v[g]), .mosi(mosi_v[g]), .miso(miso)
        );
    end

    assign sck   = sck_v[sel];
    assign csb   = csb_v[sel];
    assign mosi  = mosi_v[sel];
    assign busy  = busy_v[sel];
    assign done  = done_v[sel];
    assign ack   = ack_v[sel];
    assign rv    = rv_v[sel];
    assign rdata = rdata_v[sel];
    assign div   = sel == 0 ? 2 : (sel == 1 ? 1 : 255);
    assign wdata = wd_arr[wd_idx & 7];
    assign miso  = sidx < 16 ? 1'b1 : (sidx < 80 ? slv_data[63 - ((sidx - 16) & 63)] : 1'b0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave model: byte/phase scoreboard checks, miso shifting, wdata sequencing
    always @(negedge clk) begin
        if (resetn) begin
            if (!csb && p_csb) begin
                frames++;
                nbit = 0;
                sidx = 0;
                last_t = cyc;
            end
            if (sck != p_sck || (csb && !p_csb) || (!busy && p_busy)) begin
                check("phase_len", cyc - last_t, div);
                last_t = cyc;
            end
            if (sck && !p_sck) begin
                pulses++;
                mb = {mb[6:0], mosi};
                nbit++;
                if (nbit % 8 == 0)
                    check("mosi_byte", {24'h0, mb}, exp_mosi.size() > 0 ? {24'h0, exp_mosi.pop_front()} : 32'hFFFFFFFF);
            end
            if (!sck && p_sck) sidx++;
            if (ack) begin
                acks++;
                wd_idx++;
            end
            if (csb && !p_csb) wd_idx = 0;
            if (rv) begin
                rvs++;
                check("rdata", {24'h0, rdata}, exp_rd.size() > 0 ? {24'h0, exp_rd.pop_front()} : 32'hFFFFFFFF);
            end
            if (done) begin
                dones++;
                done_at = cyc - t0;
            end
            if (!busy && p_busy) bfall_at = cyc - t0;
        end else begin
            wd_idx = 0;
        end
        p_sck = sck;
        p_csb = csb;
        p_busy = busy;
    end

    task automatic launch(input int s, input logic w, input logic r, input logic [7:0] a, input logic [2:0] nb);
        sel = s;
        @(posedge clk); #1;
        wr = w; rd = r; addr = a; nbytes = nb; start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("csb_low_edge1", {31'h0, csb}, 0);
        check("busy_high_edge1", {31'h0, busy}, 1);
    endtask

    task automatic run(input int s, input logic w, input logic r, input logic [7:0] a, input logic [2:0] nb,
                       input int exp_done, input int exp_bfall, input int mid);
        int d, p0, a0, r0, d0, f0;
        d = nb == 3'd0 ? 8 : int'(nb);
        p0 = pulses; a0 = acks; r0 = rvs; d0 = dones; f0 = frames;
        exp_mosi.push_back({w, r, nb, 3'b000});
        exp_mosi.push_back(a);
        for (int i = 0; i < d; i++) exp_mosi.push_back(w ? wd_arr[i] : 8'h00);
        if (r) for (int i = 0; i < d; i++) exp_rd.push_back(slv_data[63 - 8 * i -: 8]);
        launch(s, w, r, a, nb);
        for (int n = 0; n < 20000 && busy; n++) begin
            if (n == mid) begin
                wr = 1'b1; rd = 1'b1; addr = 8'hFF; nbytes = 3'd3; start = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_timeout", {31'h0, busy}, 0);
        repeat (4) @(negedge clk);
        #1;
        check("sck_pulses", pulses - p0, 8 * (2 + d));
        check("wdata_acks", acks - a0, w ? d : 0);
        check("rdata_valids", rvs - r0, r ? d : 0);
        check("done_pulses", dones - d0, 1);
        check("frames", frames - f0, 1);
        check("done_edge", done_at, exp_done);
        check("busy_fall_edge", bfall_at, exp_bfall);
        check("mosi_queue_empty", exp_mosi.size(), 0);
        check("rdata_queue_empty", exp_rd.size(), 0);
    endtask

    initial begin
        int d0, f0, p0;
        for (int i = 0; i < 8; i++) wd_arr[i] = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        check("rst_csb", {29'h0, csb_v}, 3'b111);
        check("rst_sck", {29'h0, sck_v}, 0);
        check("rst_mosi", {29'h0, mosi_v}, 0);
        check("rst_busy", {29'h0, busy_v}, 0);
        check("rst_done", {29'h0, done_v}, 0);
        check("rst_ack", {29'h0, ack_v}, 0);
        check("rst_rvalid", {29'h0, rv_v}, 0);
        check("rst_rdata", {24'h0, rdata_v[0]}, 0);
        resetn = 1'b1;

        wd_arr[0] = 8'hA5;
        run(0, 1'b1, 1'b0, 8'h08, 3'd1, 99, 101, -1);
        check("rdata_unchanged_wr_only", {24'h0, rdata}, 0);

        slv_data = {8'h56, 8'h04, 48'h0};
        run(1, 1'b0, 1'b1, 8'h01, 3'd2, 66, 67, -1);

        wd_arr = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        slv_data = 64'h1122_3344_5566_7788;
        run(0, 1'b1, 1'b1, 8'h3C, 3'd0, 323, 325, 40);

        sel = 0;
        d0 = dones; f0 = frames; p0 = pulses;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; addr = 8'h55; nbytes = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("noop_busy", {31'h0, busy}, 0);
        check("noop_frames", frames - f0, 0);
        check("noop_sck", pulses - p0, 0);

        wd_arr[0] = 8'h99;
        exp_mosi.push_back(8'h88);
        launch(0, 1'b1, 1'b0, 8'h33, 3'd1);
        repeat (48) @(posedge clk);
        #2;
        d0 = dones;
        resetn = 1'b0;
        #1;
        check("midrst_csb", {31'h0, csb}, 1);
        check("midrst_sck", {31'h0, sck}, 0);
        check("midrst_busy", {31'h0, busy}, 0);
        check("midrst_mosi", {31'h0, mosi}, 0);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", dones - d0, 0);
        check("midrst_queue", exp_mosi.size(), 0);

        wd_arr[0] = 8'h3C;
        run(0, 1'b1, 1'b0, 8'h42, 3'd1, 99, 101, -1);

        wd_arr[0] = 8'h5A;
        run(2, 1'b1, 1'b0, 8'h10, 3'd1, 12496, 12751, -1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/housekeeping_spi_master.md
# housekeeping_spi_master

Clocked SPI initiator that drives the housekeeping SPI slave from the system side (test harness, debug bridge or second chip). It accepts byte-level transaction requests, serialises the command, address and data bytes in the slave's format, and returns readback bytes. SPI mode 0, MSB first, SCK derived from the system clock by a programmable divider.

## Interface
- CLKDIV, default 4: SCK half-period in clk cycles, legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request strobe; accepted only when busy=0.
- wr  input  1  write flag, sampled with start.
- rd  input  1  read flag, sampled with start.
- addr  input  8  register address, sampled with start.
- nbytes  input  3  data byte count 1..7; 0 = streaming (8 bytes), sampled with start.
- wdata  input  8  write byte, latched at each data-byte start.
- wdata_ack  output  1  one-cycle pulse when wdata is latched.
- rdata  output  8  last received data byte.
- rdata_valid  output  1  one-cycle pulse when rdata updates.
- busy  output  1  transaction or inter-frame gap in progress.
- done  output  1  one-cycle pulse when CSB deasserts.
- sck  output  1  SPI clock, idle low.
- csb  output  1  SPI chip select, active low.
- mosi  output  1  to slave SDI.
- miso  input  1  from slave SDO.

## Operation
- Reset values: sck=0, csb=1, mosi=0, busy=0, done=0, wdata_ack=0, rdata=8'h00, rdata_valid=0.
- start with wr=rd=0 is ignored (busy stays 0). start while busy=1 is ignored, no side effects.
- Frame: command byte {wr, rd, nbytes, 3'b000}, address byte addr, then D data bytes; D=nbytes, or 8 if nbytes=0. Total bits N = 8*(2+D).
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: on valid start, latch wr/rd/addr/nbytes, go SETUP.
  - SETUP: csb=0, mosi=command bit 7, sck low for CLKDIV cycles.
  - SHIFT: per bit, sck high CLKDIV cycles then low CLKDIV cycles. On the clk edge raising sck, shift miso into receive register. On the edge lowering sck, mosi advances to next bit. After bit N's low edge go HOLD.
  - HOLD: sck low, CLKDIV cycles, then csb=1, done=1, go GAP.
  - GAP: csb high CLKDIV cycles, then busy=0, IDLE.
- Write data: at the edge where mosi presents bit 7 of each data byte, wdata is latched and wdata_ack pulses. If wr=0, mosi=0 throughout data bytes.
- Read data: miso bits during command/address are discarded. If rd=1, after the 8th rising edge of each data byte rdata takes the byte and rdata_valid pulses the following cycle; if rd=0, rdata unchanged, no pulse.
- Divider counter width 8 bits; bit counter 3 bits wraps 7->0 per byte; byte counter 4 bits.
- Reset asserted mid-frame: immediately csb=1, sck=0, all outputs to reset values; no done pulse.

## Timing
- start sampled at edge 0: csb=0, busy=1 after edge 1; first sck rise at edge 1+CLKDIV.
- Bit k (1..N) rising edge at 1+(2k-1)*CLKDIV, falling edge at 1+2k*CLKDIV.
- csb rises and done pulses at edge 1+(2N+1)*CLKDIV; busy falls at 1+(2N+2)*CLKDIV; next start accepted that cycle.
- mosi stable ≥CLKDIV cycles before and after every sck rise; miso sampled CLKDIV cycles after the slave's update edge.

## Test plan
- CLKDIV=2, wr=1, addr=8'h08, nbytes=1, wdata=8'hA5 -> mosi stream 8'h88, 8'h08, 8'hA5; 24 sck pulses; one wdata_ack; done at edge 99, busy low at 101.
- CLKDIV=1, rd=1, addr=8'h01, nbytes=2, slave model returns 8'h56, 8'h04 -> command 8'h50; rdata_valid twice with 8'h56 then 8'h04; mosi=0 in data bytes.
- wr=rd=1, nbytes=0 against slave model -> command 8'hC0, exactly 8 data bytes, 8 wdata_ack and 8 rdata_valid pulses, csb rises after bit 80.
- start with wr=rd=0 -> no csb/sck activity, busy stays 0; start pulsed mid-frame -> frame unchanged, no second frame.
- resetn low during address byte -> csb=1, sck=0, busy=0 same cycle; no done; next start produces a clean full frame.
- CLKDIV=255, single-byte write -> all phase lengths exactly 255 cycles, no divider overflow.
